// File: rtl/integrate_dump.sv
// integrate_dump: sums N add/sub-tagged signed samples in a wrapping accumulator and dumps the block sum.
// Result registers one cycle after the Nth accept; only the block-completing sample stalls while a result waits.
module integrate_dump #(
  parameter int W     = 8,
  parameter int ACC_W = 16,
  parameter int N     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     x_in,
  input  logic             x_sub,
  input  logic             x_valid,
  output logic             x_ready,
  output logic [ACC_W-1:0] y_out,
  output logic             y_ovf,
  output logic             y_valid,
  input  logic             y_ready
);

  localparam int            CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [0:0]    S_ACC    = 1'b0;
  localparam logic [0:0]    S_HOLD   = 1'b1;

  logic [0:0]       state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] xs;
  logic [ACC_W-1:0] opb;
  logic [ACC_W-1:0] nxt;
  logic [CW-1:0]    cnt;
  logic             ovf_acc;
  logic             ov;
  logic             last;
  logic             accept;
  logic             transfer;

  // Subtract is done as add of the negated operand so one overflow rule covers both.
  always_comb begin
    xs  = ACC_W'($signed(x_in));
    opb = x_sub ? (~xs + ACC_W'(1)) : xs;
    nxt = acc + opb;
    ov  = (acc[ACC_W-1] == opb[ACC_W-1]) && (nxt[ACC_W-1] != acc[ACC_W-1]);
  end

  assign y_valid  = (state == S_HOLD);
  assign last     = (cnt == CNT_LAST);
  assign x_ready  = ~(y_valid & ~y_ready & last);
  assign accept   = x_valid & x_ready;
  assign transfer = y_valid & y_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_ACC;
      acc     <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
      y_out   <= '0;
      y_ovf   <= 1'b0;
    end else begin
      if (accept) begin
        if (last) begin
          y_out   <= nxt;
          y_ovf   <= ovf_acc | ov;
          acc     <= '0;
          cnt     <= '0;
          ovf_acc <= 1'b0;
        end else begin
          acc     <= nxt;
          cnt     <= cnt + CW'(1);
          ovf_acc <= ovf_acc | ov;
        end
      end
      // A completing accept on the same edge as a transfer keeps the output full.
      if (accept && last) begin
        state <= S_HOLD;
      end else if (transfer) begin
        state <= S_ACC;
      end
    end
  end

endmodule

// File: tb/tb_integrate_dump.sv
// Directed bench for integrate_dump: N=4 instance for block sums, N=1 instance for per-sample dumps.
module tb_integrate_dump;

  logic       clk = 1'b0;
  logic       reset;

  logic [7:0] x_in;
  logic       x_sub;
  logic       x_valid;
  logic       x_ready;
  logic [9:0] y_out;
  logic       y_ovf;
  logic       y_valid;
  logic       y_ready;

  logic [7:0] x1_in;
  logic       x1_sub;
  logic       x1_valid;
  logic       x1_ready;
  logic [9:0] y1_out;
  logic       y1_ovf;
  logic       y1_valid;
  logic       y1_ready;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  integrate_dump #(.W(8), .ACC_W(10), .N(4)) dut (
    .clk(clk), .reset(reset),
    .x_in(x_in), .x_sub(x_sub), .x_valid(x_valid), .x_ready(x_ready),
    .y_out(y_out), .y_ovf(y_ovf), .y_valid(y_valid), .y_ready(y_ready)
  );

  integrate_dump #(.W(8), .ACC_W(10), .N(1)) dut1 (
    .clk(clk), .reset(reset),
    .x_in(x1_in), .x_sub(x1_sub), .x_valid(x1_valid), .x_ready(x1_ready),
    .y_out(y1_out), .y_ovf(y1_ovf), .y_valid(y1_valid), .y_ready(y1_ready)
  );

  function automatic logic [15:0] ye(input int v);
    logic [9:0] t;
    t = 10'(v);
    return {6'b0, t};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v, input logic sub);
    x_valid = 1'b1;
    x_in    = 8'(v);
    x_sub   = sub;
    tick();
  endtask

  task automatic send1(input int v, input logic sub);
    x1_valid = 1'b1;
    x1_in    = 8'(v);
    x1_sub   = sub;
    tick();
  endtask

  initial begin
    reset    = 1'b0;
    x_in     = '0;
    x_sub    = 1'b0;
    x_valid  = 1'b0;
    y_ready  = 1'b1;
    x1_in    = '0;
    x1_sub   = 1'b0;
    x1_valid = 1'b0;
    y1_ready = 1'b1;

    #2;
    chk("rst_y_valid", 16'(y_valid), 16'd0);
    chk("rst_y_out",   16'(y_out),   16'd0);
    chk("rst_y_ovf",   16'(y_ovf),   16'd0);
    chk("rst_x_ready", 16'(x_ready), 16'd1);
    chk("rst_y1_valid", 16'(y1_valid), 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();

    // Plain add block
    send(10, 1'b0);
    send(20, 1'b0);
    send(30, 1'b0);
    chk("add_not_yet_valid", 16'(y_valid), 16'd0);
    send(40, 1'b0);
    chk("add_valid", 16'(y_valid), 16'd1);
    chk("add_y_out", 16'(y_out),   ye(100));
    chk("add_y_ovf", 16'(y_ovf),   16'd0);
    x_valid = 1'b0;
    tick();
    chk("add_valid_one_cycle", 16'(y_valid), 16'd0);

    // Mixed add/subtract: 50 + 20 - 30 - 7
    send(50, 1'b0);
    send(-20, 1'b1);
    send(30, 1'b1);
    send(-7, 1'b0);
    chk("mix_valid", 16'(y_valid), 16'd1);
    chk("mix_y_out", 16'(y_out),   ye(33));
    chk("mix_y_ovf", 16'(y_ovf),   16'd0);

    // Overflow: subtracting -128 four times reaches +512, wraps to -512
    send(-128, 1'b1);
    chk("mix_transferred", 16'(y_valid), 16'd0);
    send(-128, 1'b1);
    send(-128, 1'b1);
    send(-128, 1'b1);
    chk("ovf_y_out", 16'(y_out), ye(-512));
    chk("ovf_y_ovf", 16'(y_ovf), 16'd1);
    send(1, 1'b0);
    chk("ovf_transferred", 16'(y_valid), 16'd0);
    send(1, 1'b0);
    send(1, 1'b0);
    send(1, 1'b0);
    chk("post_ovf_y_out", 16'(y_out), ye(4));
    chk("post_ovf_y_ovf", 16'(y_ovf), 16'd0);
    x_valid = 1'b0;
    tick();

    // Backpressure: result 10 held, 5..7 accepted, 8 stalls until y_ready
    y_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(i, 1'b0);
    chk("bp_valid", 16'(y_valid), 16'd1);
    chk("bp_y_out", 16'(y_out),   ye(10));
    for (int i = 5; i <= 7; i++) begin
      x_valid = 1'b1;
      x_in    = 8'(i);
      x_sub   = 1'b0;
      #1;
      chk($sformatf("bp_accept_%0d", i), 16'(x_ready), 16'd1);
      tick();
    end
    x_in = 8'd8;
    #1;
    chk("bp_stall_8", 16'(x_ready), 16'd0);
    tick();
    chk("bp_hold_valid", 16'(y_valid), 16'd1);
    chk("bp_hold_y_out", 16'(y_out),   ye(10));
    chk("bp_still_stalled", 16'(x_ready), 16'd0);
    y_ready = 1'b1;
    #1;
    chk("bp_release_ready", 16'(x_ready), 16'd1);
    tick();
    chk("bp_b2b_valid", 16'(y_valid), 16'd1);
    chk("bp_b2b_y_out", 16'(y_out),   ye(26));
    x_valid = 1'b0;
    tick();
    chk("bp_drained", 16'(y_valid), 16'd0);

    // Reset mid-block discards the partial sum
    send(5, 1'b0);
    send(5, 1'b0);
    x_valid = 1'b0;
    reset   = 1'b0;
    #1;
    chk("mid_rst_y_out",   16'(y_out),   16'd0);
    chk("mid_rst_y_valid", 16'(y_valid), 16'd0);
    chk("mid_rst_y_ovf",   16'(y_ovf),   16'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) send(1, 1'b0);
    chk("after_rst_valid", 16'(y_valid), 16'd1);
    chk("after_rst_y_out", 16'(y_out),   ye(4));
    x_valid = 1'b0;
    tick();

    // N=1: every sample dumps, back-to-back
    send1(3, 1'b0);
    chk("n1_a_valid", 16'(y1_valid), 16'd1);
    chk("n1_a_y_out", 16'(y1_out),   ye(3));
    chk("n1_a_ready", 16'(x1_ready), 16'd1);
    send1(-3, 1'b1);
    chk("n1_b_valid", 16'(y1_valid), 16'd1);
    chk("n1_b_y_out", 16'(y1_out),   ye(3));
    send1(127, 1'b0);
    chk("n1_c_valid", 16'(y1_valid), 16'd1);
    chk("n1_c_y_out", 16'(y1_out),   ye(127));
    chk("n1_c_y_ovf", 16'(y1_ovf),   16'd0);
    x1_valid = 1'b0;
    tick();
    chk("n1_drained", 16'(y1_valid), 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
